// File: rtl/bp_be_pipe_mem_tracked.sv
// Memory pipe with an in-order tracker of up to inflight_p int load/store ops.
// Aligned ops go to the MMU through one command slot; misaligned ops retire locally as exceptions.
module bp_be_pipe_mem_tracked #(
  parameter  int vaddr_width_p = 39,
  parameter  int data_width_p  = 64,
  parameter  int inflight_p    = 4,
  localparam int tag_width_lp  = $clog2(inflight_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     issue_v_i,
  output logic                     issue_ready_o,
  input  logic                     issue_store_i,
  input  logic [1:0]               issue_size_i,
  input  logic                     issue_unsigned_i,
  input  logic [data_width_p-1:0]  rs1_i,
  input  logic [data_width_p-1:0]  rs2_i,
  input  logic [data_width_p-1:0]  imm_i,
  input  logic                     flush_i,
  output logic                     cmd_v_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_store_o,
  output logic [1:0]               cmd_size_o,
  output logic [vaddr_width_p-1:0] cmd_vaddr_o,
  output logic [data_width_p-1:0]  cmd_data_o,
  output logic [tag_width_lp-1:0]  cmd_tag_o,
  input  logic                     resp_v_i,
  output logic                     resp_ready_o,
  input  logic [tag_width_lp-1:0]  resp_tag_i,
  input  logic [data_width_p-1:0]  resp_data_i,
  input  logic                     resp_fault_i,
  input  logic                     resp_miss_i,
  output logic                     result_v_o,
  output logic [data_width_p-1:0]  result_data_o,
  output logic                     exc_v_o,
  output logic                     miss_v_o,
  output logic                     misaligned_o,
  output logic                     err_o
);

  localparam int cnt_width_lp = tag_width_lp + 1;
  localparam logic [cnt_width_lp-1:0] depth_lp = cnt_width_lp'(inflight_p);

  logic [inflight_p-1:0]   ent_store_q, ent_unsigned_q, ent_local_q, ent_killed_q;
  logic [1:0]              ent_size_q [inflight_p];
  logic [tag_width_lp-1:0] head_q, tail_q;
  logic [cnt_width_lp-1:0] count_q, count_d;

  logic                     cmd_v_q, cmd_store_q;
  logic [1:0]               cmd_size_q;
  logic [vaddr_width_p-1:0] cmd_vaddr_q;
  logic [data_width_p-1:0]  cmd_data_q;
  logic [tag_width_lp-1:0]  cmd_tag_q;

  logic                    result_v_q, exc_q, miss_q, misaligned_q, err_q;
  logic [data_width_p-1:0] result_data_q;

  logic [data_width_p-1:0]  sum;
  logic [vaddr_width_p-1:0] vaddr;
  logic                     misaligned, push, cmd_load, drop;
  logic [data_width_p-1:0]  st_data, ld_ext;
  logic                     not_empty, head_local, head_store, head_unsigned, head_killed;
  logic [1:0]               head_size;
  logic                     local_pop, resp_ok, pop, retire;
  logic                     unused_sum_hi;

  assign sum           = rs1_i + imm_i;
  assign vaddr         = sum[vaddr_width_p-1:0];
  assign unused_sum_hi = ^sum[data_width_p-1:vaddr_width_p];

  always_comb begin
    misaligned = 1'b0;
    case (issue_size_i)
      2'd1:    misaligned = vaddr[0];
      2'd2:    misaligned = |vaddr[1:0];
      2'd3:    misaligned = |vaddr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    st_data = rs2_i;
    case (issue_size_i)
      2'd0:    st_data = data_width_p'(rs2_i[7:0]);
      2'd1:    st_data = data_width_p'(rs2_i[15:0]);
      2'd2:    st_data = data_width_p'(rs2_i[31:0]);
      default: st_data = rs2_i;
    endcase
  end

  // A pop in this cycle deliberately does not make room for an issue.
  assign issue_ready_o = ~flush_i & (count_q < depth_lp) & (~cmd_v_q | cmd_ready_i);
  assign push          = issue_v_i & issue_ready_o;
  assign cmd_load      = push & ~misaligned;
  assign drop          = flush_i & cmd_v_q & ~cmd_ready_i;

  assign not_empty     = (count_q != '0);
  assign head_local    = ent_local_q[head_q];
  assign head_store    = ent_store_q[head_q];
  assign head_unsigned = ent_unsigned_q[head_q];
  assign head_killed   = ent_killed_q[head_q];
  assign head_size     = ent_size_q[head_q];

  assign local_pop = not_empty & head_local;
  assign resp_ok   = resp_v_i & not_empty & ~head_local & (resp_tag_i == head_q);
  assign pop       = local_pop | resp_ok;
  // A flush also silences whatever pops in the same cycle.
  assign retire    = pop & ~head_killed & ~flush_i;

  always_comb begin
    ld_ext = resp_data_i;
    case (head_size)
      2'd0:    ld_ext = {{(data_width_p-8){~head_unsigned & resp_data_i[7]}}, resp_data_i[7:0]};
      2'd1:    ld_ext = {{(data_width_p-16){~head_unsigned & resp_data_i[15]}}, resp_data_i[15:0]};
      2'd2:    ld_ext = {{(data_width_p-32){~head_unsigned & resp_data_i[31]}}, resp_data_i[31:0]};
      default: ld_ext = resp_data_i;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + cnt_width_lp'(1);
    if (pop)  count_d = count_d - cnt_width_lp'(1);
    if (drop) count_d = count_d - cnt_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ent_store_q    <= '0;
      ent_unsigned_q <= '0;
      ent_local_q    <= '0;
      ent_killed_q   <= '0;
      for (int i = 0; i < inflight_p; i++) ent_size_q[i] <= 2'd0;
    end else begin
      if (flush_i) ent_killed_q <= '1;
      if (push) begin
        ent_store_q[tail_q]    <= issue_store_i;
        ent_unsigned_q[tail_q] <= issue_unsigned_i;
        ent_local_q[tail_q]    <= misaligned;
        ent_killed_q[tail_q]   <= 1'b0;
        ent_size_q[tail_q]     <= issue_size_i;
      end
    end
  end

  // The unsent command is always the youngest entry, so dropping it rewinds the tail.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (pop) head_q <= head_q + tag_width_lp'(1);
      if (push)      tail_q <= tail_q + tag_width_lp'(1);
      else if (drop) tail_q <= tail_q - tag_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_v_q     <= 1'b0;
      cmd_store_q <= 1'b0;
      cmd_size_q  <= 2'd0;
      cmd_vaddr_q <= '0;
      cmd_data_q  <= '0;
      cmd_tag_q   <= '0;
    end else if (flush_i) begin
      cmd_v_q <= 1'b0;
    end else if (cmd_load) begin
      cmd_v_q     <= 1'b1;
      cmd_store_q <= issue_store_i;
      cmd_size_q  <= issue_size_i;
      cmd_vaddr_q <= vaddr;
      cmd_data_q  <= st_data;
      cmd_tag_q   <= tail_q;
    end else if (cmd_ready_i) begin
      cmd_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      result_v_q    <= 1'b0;
      result_data_q <= '0;
      exc_q         <= 1'b0;
      miss_q        <= 1'b0;
      misaligned_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      result_v_q    <= retire;
      exc_q         <= retire & (head_local | resp_fault_i);
      miss_q        <= retire & ~head_local & ~resp_fault_i & resp_miss_i;
      misaligned_q  <= retire & head_local;
      result_data_q <= (retire & ~head_local & ~resp_fault_i & ~resp_miss_i & ~head_store)
                       ? ld_ext : '0;
      err_q         <= err_q | (resp_v_i & ~resp_ok);
    end
  end

  assign cmd_v_o       = cmd_v_q;
  assign cmd_store_o   = cmd_store_q;
  assign cmd_size_o    = cmd_size_q;
  assign cmd_vaddr_o   = cmd_vaddr_q;
  assign cmd_data_o    = cmd_data_q;
  assign cmd_tag_o     = cmd_tag_q;
  assign resp_ready_o  = 1'b1;
  assign result_v_o    = result_v_q;
  assign result_data_o = result_data_q;
  assign exc_v_o       = exc_q;
  assign miss_v_o      = miss_q;
  assign misaligned_o  = misaligned_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bp_be_pipe_mem_tracked.sv
// Directed bench for bp_be_pipe_mem_tracked: each scenario task checks hand-computed values inline.
module tb_bp_be_pipe_mem_tracked;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue_v, issue_ready, issue_store, issue_unsigned;
  logic [1:0]  issue_size;
  logic [63:0] rs1, rs2, imm;
  logic        flush;
  logic        cmd_v, cmd_ready, cmd_store;
  logic [1:0]  cmd_size;
  logic [38:0] cmd_vaddr;
  logic [63:0] cmd_data;
  logic [1:0]  cmd_tag;
  logic        resp_v, resp_ready, resp_fault, resp_miss;
  logic [1:0]  resp_tag;
  logic [63:0] resp_data;
  logic        result_v, exc_v, miss_v, misaligned, err;
  logic [63:0] result_data;

  int n_checks = 0;
  int n_fail   = 0;

  bp_be_pipe_mem_tracked dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .issue_v_i(issue_v), .issue_ready_o(issue_ready), .issue_store_i(issue_store),
    .issue_size_i(issue_size), .issue_unsigned_i(issue_unsigned),
    .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .flush_i(flush),
    .cmd_v_o(cmd_v), .cmd_ready_i(cmd_ready), .cmd_store_o(cmd_store), .cmd_size_o(cmd_size),
    .cmd_vaddr_o(cmd_vaddr), .cmd_data_o(cmd_data), .cmd_tag_o(cmd_tag),
    .resp_v_i(resp_v), .resp_ready_o(resp_ready), .resp_tag_i(resp_tag), .resp_data_i(resp_data),
    .resp_fault_i(resp_fault), .resp_miss_i(resp_miss),
    .result_v_o(result_v), .result_data_o(result_data), .exc_v_o(exc_v), .miss_v_o(miss_v),
    .misaligned_o(misaligned), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    issue_v = 0; issue_store = 0; issue_size = 0; issue_unsigned = 0;
    rs1 = 0; rs2 = 0; imm = 0; flush = 0; cmd_ready = 0;
    resp_v = 0; resp_tag = 0; resp_data = 0; resp_fault = 0; resp_miss = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    #1;
  endtask

  task automatic set_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] d);
    issue_v = 1; issue_store = st; issue_size = sz; issue_unsigned = uns;
    rs1 = a; imm = b; rs2 = d;
  endtask

  task automatic set_resp(input logic [1:0] t, input logic [63:0] d, input logic f, input logic m);
    resp_v = 1; resp_tag = t; resp_data = d; resp_fault = f; resp_miss = m;
  endtask

  task automatic test_reset();
    set_idle();
    #1 reset_n = 0;
    #1;
    n_checks++; if (cmd_v !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_v: got %b exp 0", cmd_v); end
    n_checks++; if ({result_v, exc_v, miss_v, misaligned, err} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b exp 00000", {result_v, exc_v, miss_v, misaligned, err}); end
    n_checks++; if ({cmd_vaddr, cmd_data, result_data} !== '0) begin n_fail++; $display("FAIL rst_fields: got %h/%h/%h exp 0", cmd_vaddr, cmd_data, result_data); end
    n_checks++; if ({issue_ready, resp_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_ready: got %b exp 11", {issue_ready, resp_ready}); end
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    tick();
    n_checks++; if ({cmd_v, result_v, err} !== 3'b0) begin n_fail++; $display("FAIL rst_idle: got %b exp 000", {cmd_v, result_v, err}); end
    $display("test_reset done");
  endtask

  task automatic test_lb_signed();
    do_reset();
    set_op(0, 2'd0, 0, 64'h1000, 64'h3, 64'h0);
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready: got %b exp 1", issue_ready); end
    tick();
    issue_v = 0;
    n_checks++; if (cmd_v !== 1'b1) begin n_fail++; $display("FAIL lb_cmd_v: got %b exp 1", cmd_v); end
    n_checks++; if (cmd_vaddr !== 39'h1003) begin n_fail++; $display("FAIL lb_vaddr: got %h exp %h", cmd_vaddr, 39'h1003); end
    n_checks++; if ({cmd_tag, cmd_store, cmd_size} !== 5'b0) begin n_fail++; $display("FAIL lb_cmd_fields: got %b exp 00000", {cmd_tag, cmd_store, cmd_size}); end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    n_checks++; if (cmd_v !== 1'b0) begin n_fail++; $display("FAIL lb_cmd_drop: got %b exp 0", cmd_v); end
    set_resp(2'd0, 64'h80, 0, 0);
    tick();
    resp_v = 0;
    n_checks++; if (result_v !== 1'b1) begin n_fail++; $display("FAIL lb_result_v: got %b exp 1", result_v); end
    n_checks++; if (result_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h exp FFFFFFFFFFFFFF80", result_data); end
    n_checks++; if ({exc_v, miss_v, misaligned} !== 3'b0) begin n_fail++; $display("FAIL lb_flags: got %b exp 000", {exc_v, miss_v, misaligned}); end
    tick();
    n_checks++; if (result_v !== 1'b0) begin n_fail++; $display("FAIL lb_one_retire: got %b exp 0", result_v); end
    $display("test_lb_signed done");
  endtask

  task automatic test_misaligned();
    do_reset();
    set_op(0, 2'd2, 0, 64'h1000, 64'h2, 64'h0);
    tick();
    issue_v = 0;
    n_checks++; if ({cmd_v, result_v} !== 2'b00) begin n_fail++; $display("FAIL mis_nocmd: got %b exp 00", {cmd_v, result_v}); end
    tick();
    n_checks++; if ({result_v, exc_v, misaligned, miss_v} !== 4'b1110) begin n_fail++; $display("FAIL mis_flags: got %b exp 1110", {result_v, exc_v, misaligned, miss_v}); end
    n_checks++; if (result_data !== 64'h0) begin n_fail++; $display("FAIL mis_data: got %h exp 0", result_data); end
    tick();
    n_checks++; if ({result_v, cmd_v, err} !== 3'b000) begin n_fail++; $display("FAIL mis_after: got %b exp 000", {result_v, cmd_v, err}); end
    $display("test_misaligned done");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(0, 2'd3, 0, 64'h2000, 64'h8, 64'h0);
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b exp 1", issue_ready); end
    tick();
    imm = 64'h10;
    #1;
    n_checks++; if ({cmd_v, cmd_tag, cmd_vaddr} !== {1'b1, 2'd0, 39'h2008}) begin n_fail++; $display("FAIL bp_cmd0: got %b/%0d/%h exp 1/0/2008", cmd_v, cmd_tag, cmd_vaddr); end
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy: got %b exp 0", issue_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if ({cmd_v, cmd_tag, cmd_vaddr, issue_ready} !== {1'b1, 2'd0, 39'h2008, 1'b0}) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%0d/%h/%b exp 1/0/2008/0", c, cmd_v, cmd_tag, cmd_vaddr, issue_ready); end
    end
    cmd_ready = 1;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b exp 1", issue_ready); end
    tick();
    n_checks++; if ({cmd_tag, cmd_vaddr} !== {2'd1, 39'h2010}) begin n_fail++; $display("FAIL bp_cmd1: got %0d/%h exp 1/2010", cmd_tag, cmd_vaddr); end
    imm = 64'h18;
    tick();
    n_checks++; if (cmd_tag !== 2'd2) begin n_fail++; $display("FAIL bp_cmd2: got %0d exp 2", cmd_tag); end
    imm = 64'h20;
    tick();
    n_checks++; if ({cmd_tag, cmd_vaddr} !== {2'd3, 39'h2020}) begin n_fail++; $display("FAIL bp_cmd3: got %0d/%h exp 3/2020", cmd_tag, cmd_vaddr); end
    imm = 64'h28;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b exp 0", issue_ready); end
    tick();
    cmd_ready = 0;
    #1;
    n_checks++; if ({cmd_v, issue_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_full_idle: got %b exp 00", {cmd_v, issue_ready}); end
    set_resp(2'd0, 64'h8000_0000_0000_0000, 0, 0);
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_free: got %b exp 0", issue_ready); end
    tick();
    n_checks++; if ({result_v, result_data} !== {1'b1, 64'h8000_0000_0000_0000}) begin n_fail++; $display("FAIL bp_ret0: got %b/%h exp 1/8000000000000000", result_v, result_data); end
    set_resp(2'd1, 64'h8000_0000_0000_0001, 0, 0);
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL bp_freed: got %b exp 1", issue_ready); end
    tick();
    issue_v = 0;
    n_checks++; if ({result_v, result_data} !== {1'b1, 64'h8000_0000_0000_0001}) begin n_fail++; $display("FAIL bp_ret1: got %b/%h exp 1/8000000000000001", result_v, result_data); end
    n_checks++; if ({cmd_v, cmd_tag, cmd_vaddr} !== {1'b1, 2'd0, 39'h2028}) begin n_fail++; $display("FAIL bp_fifth: got %b/%0d/%h exp 1/0/2028", cmd_v, cmd_tag, cmd_vaddr); end
    for (int t = 2; t < 4; t++) begin
      set_resp(2'(t), 64'h8000_0000_0000_0000 | 64'(t), 0, 0);
      tick();
      n_checks++; if ({result_v, result_data} !== {1'b1, 64'h8000_0000_0000_0000 | 64'(t)}) begin n_fail++; $display("FAIL bp_ret%0d: got %b/%h", t, result_v, result_data); end
    end
    resp_v = 0;
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    set_resp(2'd0, 64'h1234, 0, 0);
    tick();
    resp_v = 0;
    n_checks++; if ({result_v, result_data, err} !== {1'b1, 64'h1234, 1'b0}) begin n_fail++; $display("FAIL bp_ret_wrap: got %b/%h/%b exp 1/1234/0", result_v, result_data, err); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    do_reset();
    cmd_ready = 1;
    set_op(0, 2'd3, 0, 64'h3000, 64'h0, 64'h0);
    tick();
    imm = 64'h8;
    tick();
    imm = 64'h10;
    tick();
    issue_v = 0;
    cmd_ready = 0;
    n_checks++; if ({cmd_v, cmd_tag} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL fl_pending: got %b/%0d exp 1/2", cmd_v, cmd_tag); end
    flush = 1;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready: got %b exp 0", issue_ready); end
    tick();
    flush = 0;
    n_checks++; if (cmd_v !== 1'b0) begin n_fail++; $display("FAIL fl_cmd_drop: got %b exp 0", cmd_v); end
    for (int t = 0; t < 2; t++) begin
      set_resp(2'(t), 64'h99, 0, 0);
      tick();
      n_checks++; if ({result_v, exc_v, miss_v} !== 3'b000) begin n_fail++; $display("FAIL fl_killed%0d: got %b exp 000", t, {result_v, exc_v, miss_v}); end
    end
    resp_v = 0;
    set_op(0, 2'd3, 0, 64'h3100, 64'h0, 64'h0);
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL fl_empty_ready: got %b exp 1", issue_ready); end
    tick();
    issue_v = 0;
    n_checks++; if ({cmd_v, cmd_tag} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL fl_tail_rewind: got %b/%0d exp 1/2", cmd_v, cmd_tag); end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    set_resp(2'd2, 64'h55, 0, 0);
    tick();
    resp_v = 0;
    n_checks++; if ({result_v, result_data, err} !== {1'b1, 64'h55, 1'b0}) begin n_fail++; $display("FAIL fl_recover: got %b/%h/%b exp 1/55/0", result_v, result_data, err); end
    $display("test_flush done");
  endtask

  task automatic test_bad_tag();
    do_reset();
    cmd_ready = 1;
    set_op(0, 2'd3, 0, 64'h6000, 64'h0, 64'h0);
    tick();
    issue_v = 0;
    tick();
    cmd_ready = 0;
    set_resp(2'd2, 64'h7, 0, 0);
    tick();
    resp_v = 0;
    n_checks++; if ({err, result_v} !== 2'b10) begin n_fail++; $display("FAIL tag_err: got %b exp 10", {err, result_v}); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tag_sticky: got %b exp 1", err); end
    set_resp(2'd0, 64'h77, 0, 0);
    tick();
    resp_v = 0;
    n_checks++; if ({result_v, result_data, err} !== {1'b1, 64'h77, 1'b1}) begin n_fail++; $display("FAIL tag_head_kept: got %b/%h/%b exp 1/77/1", result_v, result_data, err); end
    $display("test_bad_tag done");
  endtask

  task automatic test_store_fault();
    do_reset();
    set_op(1, 2'd1, 0, 64'h4000, 64'h2, 64'h1234_5678);
    tick();
    issue_v = 0;
    n_checks++; if (cmd_data !== 64'h5678) begin n_fail++; $display("FAIL st_data: got %h exp 5678", cmd_data); end
    n_checks++; if ({cmd_v, cmd_store, cmd_size, cmd_vaddr} !== {1'b1, 1'b1, 2'd1, 39'h4002}) begin n_fail++; $display("FAIL st_cmd: got %b/%b/%0d/%h exp 1/1/1/4002", cmd_v, cmd_store, cmd_size, cmd_vaddr); end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    set_resp(2'd0, 64'hFFFF, 1, 1);
    tick();
    resp_v = 0;
    n_checks++; if ({result_v, exc_v, miss_v, misaligned} !== 4'b1100) begin n_fail++; $display("FAIL st_fault_flags: got %b exp 1100", {result_v, exc_v, miss_v, misaligned}); end
    n_checks++; if (result_data !== 64'h0) begin n_fail++; $display("FAIL st_fault_data: got %h exp 0", result_data); end
    $display("test_store_fault done");
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz  [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] off [4] = '{64'h4, 64'h6, 64'h8, 64'h11};
    logic [63:0] raw [4] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_FFFF_8234, 64'hDEAD, 64'h1FF};
    logic        ms  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] exp_d [4] = '{64'hFFFF_FFFF_8000_0001, 64'h8234, 64'h0, 64'hFF};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_op(0, sz[i], uns[i], 64'h5000, off[i], 64'h0);
      tick();
      issue_v = 0;
      cmd_ready = 1;
      tick();
      cmd_ready = 0;
      set_resp(2'(i), raw[i], 0, ms[i]);
      tick();
      resp_v = 0;
      n_checks++; if ({result_v, result_data} !== {1'b1, exp_d[i]}) begin n_fail++; $display("FAIL ext%0d_data: got %b/%h exp 1/%h", i, result_v, result_data, exp_d[i]); end
      n_checks++; if ({miss_v, exc_v} !== {ms[i], 1'b0}) begin n_fail++; $display("FAIL ext%0d_flags: got %b exp %b0", i, {miss_v, exc_v}, ms[i]); end
    end
    $display("test_load_ext done");
  endtask

  initial begin
    set_idle();
    test_reset();
    test_lb_signed();
    test_misaligned();
    test_backpressure();
    test_flush();
    test_bad_tag();
    test_store_fault();
    test_load_ext();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_mem_tracked.md
Name: bp_be_pipe_mem_tracked

Overview:
Parametrised successor to the BE memory pipe. It accepts int load/store ops, computes vaddr and checks natural alignment locally. It issues commands to the MMU through a registered valid/ready slot and honours MMU backpressure. Up to inflight_p ops are tracked in order, responses are tag-checked, load data is extended by size/sign, and flush kills everything in flight.

Parameters:
vaddr_width_p, 39, virtual address width
data_width_p, 64, register/data width (64 only; size encodings assume RV64)
inflight_p, 4, max tracked ops (power of 2, >=2); tag_width_lp = log2(inflight_p)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
issue_v_i  in  1  op valid
issue_ready_o  out  1  op accepted when issue_v_i & issue_ready_o
issue_store_i  in  1  1=store, 0=load
issue_size_i  in  2  0=B,1=H,2=W,3=D
issue_unsigned_i  in  1  zero-extend load
rs1_i  in  data_width_p  base
rs2_i  in  data_width_p  store data
imm_i  in  data_width_p  offset
flush_i  in  1  kill all in-flight ops
cmd_v_o  out  1  MMU command valid
cmd_ready_i  in  1  MMU accepts
cmd_store_o  out  1  op type
cmd_size_o  out  2  size
cmd_vaddr_o  out  vaddr_width_p  rs1+imm, low bits
cmd_data_o  out  data_width_p  rs2 masked to size
cmd_tag_o  out  tag_width_lp  tracker slot
resp_v_i  in  1  MMU response valid
resp_ready_o  out  1  always 1
resp_tag_i  in  tag_width_lp  must equal head tag
resp_data_i  in  data_width_p  raw load data, LSB-aligned
resp_fault_i  in  1  access/page fault
resp_miss_i  in  1  cache/TLB miss
result_v_o  out  1  one op retired
result_data_o  out  data_width_p  extended load data; 0 for stores/exc/miss
exc_v_o  out  1  retired op faulted or was misaligned
miss_v_o  out  1  retired op missed
misaligned_o  out  1  retired op misaligned
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync-safe deassert): tracker empty, head=tail=0, cmd_v_o=0, all result/exc/miss/misaligned/err outputs 0, cmd_* data fields 0.
- Tracker: circular buffer of inflight_p entries {store, size, unsigned, local, killed}. Tag = slot index. Count range 0..inflight_p.
- issue_ready_o = ~flush_i & (count<inflight_p) & (~cmd_v_o | cmd_ready_i). A same-cycle pop does not free a slot for issue.
- Misaligned: vaddr[size-1:0]!=0 (B never). Entry is written with local=1 and no command is sent. It retires at the head 1 cycle after it reaches the head, with result_v_o=exc_v_o=misaligned_o=1.
- Aligned accepted op: entry written and cmd slot loaded; cmd_v_o=1 on the next cycle and held, stable, until cmd_ready_i. Issue->cmd latency 1 cycle.
- Vaddr = (rs1_i+imm_i) truncated to vaddr_width_p; wrap-around ignored.
- Response: popped when resp_v_i. If resp_tag_i!=head tag or the tracker is empty, set err_o (sticky until reset) and do not pop.
- Retire is registered, 1 cycle after the response. result_v_o=1 unless the entry is killed. Killed entries pop silently.
- Load data: take the low 8/16/32/64 bits, sign- or zero-extend; W signed sign-extends bit 31.
- Fault: exc_v_o=1, data 0. Miss: miss_v_o=1, data 0. Both asserted: exc_v_o only.
- Local and remote retire are in order; at most one retire per cycle; the head decides.
- flush_i: every tracker entry gets killed=1. An unaccepted cmd slot is cleared (cmd_v_o=0 next cycle) and its tail entry is removed. If cmd_ready_i&cmd_v_o in the flush cycle, the command counts as sent and its entry stays, killed. Killed local entries pop 1/cycle. Outputs of a retire already registered still appear.
- Simultaneous push+pop: count unchanged; pointers wrap modulo inflight_p.

Test Plan:
- LB signed, rs1=0x1000, imm=3, resp_data=0x80 -> cmd_vaddr=0x1003 one cycle after issue; result_data=0xFFFF_FFFF_FFFF_FF80 one cycle after resp.
- LW, vaddr=0x1002 -> no cmd_v_o; result_v_o=exc_v_o=misaligned_o=1, data 0.
- Four aligned loads with cmd_ready_i=0 for 3 cycles -> cmd fields stable, issue_ready_o=0 while slot busy, then low at count=4; in-order responses tags 0..3 retire; 5th issue accepted after the first pop.
- Two loads sent, third pending in cmd slot, flush_i -> cmd_v_o drops; responses for tags 0,1 produce no result_v_o; count returns to 0.
- Response with tag 2 while head=0 -> err_o=1 and stays 1; head not popped.
- Store SH rs2=0x12345678 -> cmd_data_o=0x5678; response with resp_fault_i=1, resp_miss_i=1 -> exc_v_o=1, miss_v_o=0.
